// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Sequential reducer for the four row pairs of an 8x8 half-adder-array partial-product
// generator: one weighted array is folded into a 16-bit accumulator per cycle.
module unsigned_mul_8x8_ha_array_accum #(
    parameter int TRUNC_LSB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] KEEP_MASK = 16'hFFFF << TRUNC_LSB;

    state_t      state_q, state_d;
    logic [15:0] acc_q;
    logic [1:0]  cnt_q;
    logic        out_valid_q;
    logic [15:0] product_q;
    logic        accept;

    logic [8:0]  t_in [4];
    logic [6:0]  b_in [4];
    logic [8:0]  t_q  [4];
    logic [6:0]  b_q  [4];
    logic [9:0]  row  [4];
    logic [15:0] contrib [4];

    assign t_in[0] = ha_array_0_t;
    assign t_in[1] = ha_array_1_t;
    assign t_in[2] = ha_array_2_t;
    assign t_in[3] = ha_array_3_t;
    assign b_in[0] = ha_array_0_b;
    assign b_in[1] = ha_array_1_b;
    assign b_in[2] = ha_array_2_b;
    assign b_in[3] = ha_array_3_b;

    assign accept = in_valid & in_ready;

    // Capture each array on accept; row k carries weight 4^k inside the product.
    for (genvar gi = 0; gi < 4; gi++) begin : g_array
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                t_q[gi] <= '0;
                b_q[gi] <= '0;
            end else if (accept) begin
                t_q[gi] <= t_in[gi];
                b_q[gi] <= b_in[gi];
            end
        end

        assign row[gi]     = {1'b0, t_q[gi]} + {1'b0, b_q[gi], 2'b00};
        assign contrib[gi] = {6'b0, row[gi]} << (2 * gi);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                  state_d = ACC;
            ACC:     if (cnt_q == 2'd3)             state_d = DONE;
            DONE:    if (out_valid_q && out_ready)  state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        product   = product_q;
    end

    // The DONE cycle before out_valid_q rises registers the truncated result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ACC: begin
                    acc_q <= acc_q + contrib[cnt_q];
                    cnt_q <= cnt_q + 2'd1;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        product_q   <= acc_q & KEEP_MASK;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
// Bench for the ha_array accumulator: a transaction-level latency/value model checked every
// cycle, plus directed literal vectors, on a full-width and a TRUNC_LSB=4 instance.
module tb_unsigned_mul_8x8_ha_array_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [8:0]  t_in [4];
    logic [6:0]  b_in [4];
    logic        in_ready, out_valid, in_ready4, out_valid4;
    logic [15:0] product, product4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unsigned_mul_8x8_ha_array_accum #(.TRUNC_LSB(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]), .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
        .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]), .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    unsigned_mul_8x8_ha_array_accum #(.TRUNC_LSB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]), .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
        .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]), .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
        .out_valid(out_valid4), .out_ready(out_ready), .product(product4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted row set yields sum((t+4b)*4^k) mod 2^16, visible 5 edges later,
    // held until out_ready; reset clears everything.
    logic        m_init = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_since = 0;
    logic [15:0] m_exp = '0;
    logic [15:0] m_prod = '0;

    always @(posedge clk) begin
        int s;
        if (!rst_n) begin
            m_init = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_prod = '0; m_since = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += (int'(t_in[k]) + 4 * int'(b_in[k])) << (2 * k);
                m_exp = s[15:0];
                m_busy = 1'b1; m_since = 0;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0; m_busy = 1'b0;
            end
        end else begin
            m_since++;
            if (m_since == 5) begin
                m_valid = 1'b1; m_prod = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
            check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            check("cyc_product", 32'(product), 32'(m_prod));
            check("cyc_product_trunc4", 32'(product4), 32'(m_prod & 16'hFFF0));
            check("cyc_out_valid_trunc4", 32'(out_valid4), 32'(m_valid));
        end
    end

    task automatic set_rows(input logic [8:0] t0, t1, t2, t3, input logic [6:0] b0, b1, b2, b3);
        t_in[0] = t0; t_in[1] = t1; t_in[2] = t2; t_in[3] = t3;
        b_in[0] = b0; b_in[1] = b1; b_in[2] = b2; b_in[3] = b3;
    endtask

    task automatic scramble();
        for (int k = 0; k < 4; k++) begin
            t_in[k] = 9'($urandom);
            b_in[k] = 7'($urandom);
        end
    endtask

    // Called at posedge+2 with the block idle and rows already on the inputs.
    task automatic run_op(input string name, input int hold, input logic [15:0] lit, input logic [15:0] lit4);
        int n;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        scramble();
        n = 0;
        while (n < 20) begin
            @(posedge clk); #2;
            n++;
            if (out_valid) break;
        end
        check({name, "_latency"}, 32'(n), 32'd5);
        check({name, "_product"}, 32'(product), 32'(lit));
        check({name, "_product_trunc4"}, 32'(product4), 32'(lit4));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            scramble();
            in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check({name, "_held_product"}, 32'(product), 32'(lit));
            check({name, "_held_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        check({name, "_drop_valid"}, 32'(out_valid), 32'd0);
        $display("op %s product=%0d product_trunc4=%0d latency=%0d", name, product, product4, n);
    endtask

    initial begin
        int n;
        set_rows(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check("reset_product", 32'(product), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        set_rows(0, 0, 0, 0, 0, 0, 0, 0);
        run_op("zero", 0, 16'd0, 16'd0);
        set_rows(9'h003, 0, 0, 0, 0, 0, 0, 0);
        run_op("x3y1", 0, 16'd3, 16'd0);
        set_rows(0, 0, 0, 9'h001, 0, 0, 0, 0);
        run_op("arr3_t1", 0, 16'd64, 16'd64);
        set_rows(0, 0, 0, 0, 0, 7'h01, 0, 0);
        run_op("arr1_b1", 0, 16'd16, 16'd16);
        set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        run_op("all_ones", 0, 16'd21079, 16'd21072);
        set_rows(9'h001, 9'h002, 9'h000, 9'h000, 7'h01, 0, 0, 0);
        run_op("hold10", 10, 16'd13, 16'd0);

        // Reset sampled at the edge ending the second ACC cycle aborts the operation.
        set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b0;
        check("abort_product", 32'(product), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            if (out_valid) n++;
        end
        check("abort_no_valid", 32'(n), 32'd0);
        set_rows(0, 9'h005, 0, 0, 0, 0, 0, 7'h02);
        run_op("after_abort", 2, 16'd532, 16'd528);

        for (int i = 0; i < 15000; i++) begin
            @(posedge clk); #2;
            scramble();
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("drain_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
